// File: rtl/rasterizer_pkg.sv
// Shared types and helpers for the triangle assembly stage of the rasterizer.
package rasterizer_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 18;
    localparam int INDEX_W  = 12;
    localparam int BBOX_W   = 10;

    typedef logic signed [COORD_W-1:0] coord_t;

    localparam coord_t SCREEN_X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t SCREEN_Y_MAX = coord_t'(SCREEN_H - 1);

    // Which vertex slot the next incoming vertex lands in.
    typedef enum logic [1:0] {
        VCNT_0 = 2'd0,
        VCNT_1 = 2'd1,
        VCNT_2 = 2'd2
    } vcnt_e;

    typedef struct packed {
        coord_t u;
        coord_t v;
        coord_t n;
    } projected_vertex_t;

    typedef struct packed {
        logic [BBOX_W-1:0] min_x;
        logic [BBOX_W-1:0] max_x;
        logic [BBOX_W-1:0] min_y;
        logic [BBOX_W-1:0] max_y;
    } bbox_t;

    // vtx[0] is the first vertex received.
    typedef struct packed {
        logic [INDEX_W-1:0]      index;
        projected_vertex_t [2:0] vtx;
        bbox_t                   bbox;
    } triangle_packet_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    // Depth at or behind the camera plane.
    function automatic logic is_nonpositive(input coord_t c);
        return c[COORD_W-1] || (c == coord_t'(0));
    endfunction

    // Clamp a signed coordinate into [0, hi] and keep the low bits.
    function automatic logic [BBOX_W-1:0] clamp_to_screen(input coord_t c, input coord_t hi);
        if (c[COORD_W-1]) begin
            return '0;
        end else if (c > hi) begin
            return hi[BBOX_W-1:0];
        end else begin
            return c[BBOX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/triangle_fifo.sv
// Synchronous first-word-fall-through FIFO of assembled triangles.
// The head entry is read straight out of the register array, so it is
// available in the same cycle the entry becomes valid.
module triangle_fifo
    import rasterizer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  triangle_packet_t         data_i,
    input  logic                     pop_i,
    output triangle_packet_t         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    triangle_packet_t   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/triangle_assembler.sv
// Groups projected vertices into triangles, culls near/off-screen ones,
// computes a screen-clamped bounding box and queues survivors for the
// rasterizer. Pipeline: collect (slots) -> eval register -> FIFO push.
module triangle_assembler
    import rasterizer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      data_in_i,
    input  logic [INDEX_W-1:0]        triangle_index_in_i,
    input  logic signed [COORD_W-1:0] u_i,
    input  logic signed [COORD_W-1:0] v_i,
    input  logic signed [COORD_W-1:0] n_i,
    input  logic                      clear_status_i,
    output logic                      tri_valid_o,
    input  logic                      tri_ready_i,
    output logic [INDEX_W-1:0]        tri_index_o,
    output logic [2:0][COORD_W-1:0]   tri_u_o,
    output logic [2:0][COORD_W-1:0]   tri_v_o,
    output logic [2:0][COORD_W-1:0]   tri_n_o,
    output logic [BBOX_W-1:0]         bbox_min_x_o,
    output logic [BBOX_W-1:0]         bbox_max_x_o,
    output logic [BBOX_W-1:0]         bbox_min_y_o,
    output logic [BBOX_W-1:0]         bbox_max_y_o,
    output logic                      almost_full_o,
    output logic                      seq_error_o,
    output logic                      overflow_o,
    output logic [15:0]               culled_count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);

    projected_vertex_t       in_vtx;
    projected_vertex_t [2:0] slot_q, slot_d;
    logic [INDEX_W-1:0]      idx_q, idx_d;
    vcnt_e                   vcnt_q, vcnt_d;
    logic                    asm_valid_q, asm_valid_d;
    logic                    mismatch;

    coord_t                  min_u, max_u, min_v, max_v;
    logic                    cull_d;
    triangle_packet_t        pkt_d;

    logic                    eval_valid_q;
    logic                    eval_cull_q;
    triangle_packet_t        eval_pkt_q;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                    cull_evt, drop_evt;
    logic [CNT_W-1:0]        fifo_count;
    triangle_packet_t        head;

    logic                    seq_error_q, overflow_q;
    logic [15:0]             culled_count_q;

    assign in_vtx = '{u: u_i, v: v_i, n: n_i};

    // Collect state register: slot contents, latched index and slot counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q      <= '0;
            idx_q       <= '0;
            vcnt_q      <= VCNT_0;
            asm_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            vcnt_q      <= vcnt_d;
            asm_valid_q <= asm_valid_d;
        end
    end

    // Collect next-state: place the vertex, check index continuity, fire on the third.
    always_comb begin
        slot_d      = slot_q;
        idx_d       = idx_q;
        vcnt_d      = vcnt_q;
        asm_valid_d = 1'b0;
        mismatch    = 1'b0;
        if (data_in_i) begin
            case (vcnt_q)
                VCNT_0: begin
                    slot_d[0] = in_vtx;
                    idx_d     = triangle_index_in_i;
                    vcnt_d    = VCNT_1;
                end
                VCNT_1, VCNT_2: begin
                    if (triangle_index_in_i != idx_q) begin
                        // Drop the partial triangle; this vertex starts a new one.
                        mismatch  = 1'b1;
                        slot_d[0] = in_vtx;
                        idx_d     = triangle_index_in_i;
                        vcnt_d    = VCNT_1;
                    end else if (vcnt_q == VCNT_1) begin
                        slot_d[1] = in_vtx;
                        vcnt_d    = VCNT_2;
                    end else begin
                        slot_d[2]   = in_vtx;
                        vcnt_d      = VCNT_0;
                        asm_valid_d = 1'b1;
                    end
                end
                default: vcnt_d = VCNT_0;
            endcase
        end
    end

    // Cull decision and clamped bounding box for the completed triangle in the slots.
    always_comb begin
        min_u  = min3(slot_q[0].u, slot_q[1].u, slot_q[2].u);
        max_u  = max3(slot_q[0].u, slot_q[1].u, slot_q[2].u);
        min_v  = min3(slot_q[0].v, slot_q[1].v, slot_q[2].v);
        max_v  = max3(slot_q[0].v, slot_q[1].v, slot_q[2].v);
        cull_d = is_nonpositive(slot_q[0].n) || is_nonpositive(slot_q[1].n) ||
                 is_nonpositive(slot_q[2].n) ||
                 max_u[COORD_W-1] || (min_u > SCREEN_X_MAX) ||
                 max_v[COORD_W-1] || (min_v > SCREEN_Y_MAX);
        pkt_d            = '0;
        pkt_d.index      = idx_q;
        pkt_d.vtx        = slot_q;
        pkt_d.bbox.min_x = clamp_to_screen(min_u, SCREEN_X_MAX);
        pkt_d.bbox.max_x = clamp_to_screen(max_u, SCREEN_X_MAX);
        pkt_d.bbox.min_y = clamp_to_screen(min_v, SCREEN_Y_MAX);
        pkt_d.bbox.max_y = clamp_to_screen(max_v, SCREEN_Y_MAX);
    end

    // Eval stage register, loaded one cycle after the third vertex.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eval_valid_q <= 1'b0;
            eval_cull_q  <= 1'b0;
            eval_pkt_q   <= '0;
        end else begin
            eval_valid_q <= asm_valid_q;
            if (asm_valid_q) begin
                eval_cull_q <= cull_d;
                eval_pkt_q  <= pkt_d;
            end
        end
    end

    assign fifo_pop  = tri_ready_i && !fifo_empty;
    assign fifo_push = eval_valid_q && !eval_cull_q;
    assign cull_evt  = eval_valid_q && eval_cull_q;
    assign drop_evt  = fifo_push && fifo_full && !fifo_pop;

    triangle_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (eval_pkt_q),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky status and cull counter; clear wins over a same-cycle set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_error_q    <= 1'b0;
            overflow_q     <= 1'b0;
            culled_count_q <= '0;
        end else if (clear_status_i) begin
            seq_error_q    <= 1'b0;
            overflow_q     <= 1'b0;
            culled_count_q <= {15'd0, cull_evt};
        end else begin
            seq_error_q    <= seq_error_q | mismatch;
            overflow_q     <= overflow_q | drop_evt;
            culled_count_q <= culled_count_q + {15'd0, cull_evt};
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_vtx_out
        assign tri_u_o[gi] = head.vtx[gi].u;
        assign tri_v_o[gi] = head.vtx[gi].v;
        assign tri_n_o[gi] = head.vtx[gi].n;
    end

    assign tri_valid_o    = !fifo_empty;
    assign tri_index_o    = head.index;
    assign bbox_min_x_o   = head.bbox.min_x;
    assign bbox_max_x_o   = head.bbox.max_x;
    assign bbox_min_y_o   = head.bbox.min_y;
    assign bbox_max_y_o   = head.bbox.max_y;
    assign almost_full_o  = (fifo_count >= AF_LEVEL);
    assign seq_error_o    = seq_error_q;
    assign overflow_o     = overflow_q;
    assign culled_count_o = culled_count_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Self-checking bench for triangle_assembler with a vertex-list reference model.
module tb_triangle_assembler;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               data_in = 1'b0;
    logic [11:0]        idx_in = '0;
    logic signed [17:0] u_in = '0;
    logic signed [17:0] v_in = '0;
    logic signed [17:0] n_in = '0;
    logic               clear_status = 1'b0;
    logic               tri_ready = 1'b0;
    logic               tri_valid;
    logic [11:0]        tri_index;
    logic [2:0][17:0]   tri_u, tri_v, tri_n;
    logic [9:0]         bx0, bx1, by0, by1;
    logic               af, seq_err, ovf;
    logic [15:0]        culled;

    typedef struct packed {
        logic [11:0]      idx;
        logic [2:0][17:0] u;
        logic [2:0][17:0] v;
        logic [2:0][17:0] n;
        logic [9:0]       x0;
        logic [9:0]       x1;
        logic [9:0]       y0;
        logic [9:0]       y1;
    } exp_t;

    typedef struct {
        int idx;
        int u;
        int v;
        int n;
    } vtx_t;

    vtx_t pend_q[$];
    exp_t exp_q[$];
    int   exp_culled = 0;
    bit   exp_seq = 0;
    bit   rand_ready = 0;
    int   checks = 0;
    int   errors = 0;

    localparam int ONE  = 4096;
    localparam int HALF = 2048;

    triangle_assembler #(.DEPTH(4), .AF_MARGIN(2)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .data_in_i           (data_in),
        .triangle_index_in_i (idx_in),
        .u_i                 (u_in),
        .v_i                 (v_in),
        .n_i                 (n_in),
        .clear_status_i      (clear_status),
        .tri_valid_o         (tri_valid),
        .tri_ready_i         (tri_ready),
        .tri_index_o         (tri_index),
        .tri_u_o             (tri_u),
        .tri_v_o             (tri_v),
        .tri_n_o             (tri_n),
        .bbox_min_x_o        (bx0),
        .bbox_max_x_o        (bx1),
        .bbox_min_y_o        (by0),
        .bbox_max_y_o        (by1),
        .almost_full_o       (af),
        .seq_error_o         (seq_err),
        .overflow_o          (ovf),
        .culled_count_o      (culled)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [9:0] clampi(input int c, input int extent);
        int r;
        r = (c < 0) ? 0 : ((c > extent - 1) ? extent - 1 : c);
        return r[9:0];
    endfunction

    function automatic void model_vertex(input int idx, input int u, input int v, input int n);
        vtx_t t;
        exp_t e;
        int mnu, mxu, mnv, mxv, x;
        bit near;
        if (pend_q.size() != 0 && pend_q[0].idx != idx) begin
            pend_q.delete();
            exp_seq = 1;
        end
        t.idx = idx; t.u = u; t.v = v; t.n = n;
        pend_q.push_back(t);
        if (pend_q.size() == 3) begin
            mnu = pend_q[0].u; mxu = mnu; mnv = pend_q[0].v; mxv = mnv; near = 0;
            e = '0;
            e.idx = idx[11:0];
            for (int i = 0; i < 3; i++) begin
                if (pend_q[i].u < mnu) mnu = pend_q[i].u;
                if (pend_q[i].u > mxu) mxu = pend_q[i].u;
                if (pend_q[i].v < mnv) mnv = pend_q[i].v;
                if (pend_q[i].v > mxv) mxv = pend_q[i].v;
                if (pend_q[i].n <= 0) near = 1;
                x = pend_q[i].u; e.u[i] = x[17:0];
                x = pend_q[i].v; e.v[i] = x[17:0];
                x = pend_q[i].n; e.n[i] = x[17:0];
            end
            if (near || mxu < 0 || mnu > 639 || mxv < 0 || mnv > 479) begin
                exp_culled++;
            end else begin
                e.x0 = clampi(mnu, 640); e.x1 = clampi(mxu, 640);
                e.y0 = clampi(mnv, 480); e.y1 = clampi(mxv, 480);
                exp_q.push_back(e);
            end
            pend_q.delete();
        end
    endfunction

    // Scoreboard: every accepted head must match the oldest expected triangle.
    always @(negedge clk) begin
        exp_t got, e;
        if (rst_n && tri_valid && tri_ready) begin
            got = {tri_index, tri_u, tri_v, tri_n, bx0, bx1, by0, by1};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tri_unexpected got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL tri_head got=%h exp=%h", got, e);
                end else begin
                    $display("tri idx=%0d bbox x%0d..%0d y%0d..%0d ok", tri_index, bx0, bx1, by0, by1);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_vertex(input int idx, input int u, input int v, input int n);
        if (rand_ready) tri_ready = ($urandom_range(0, 3) != 0);
        data_in = 1'b1;
        idx_in = idx[11:0];
        u_in = u[17:0];
        v_in = v[17:0];
        n_in = n[17:0];
        model_vertex(idx & 32'hFFF, u, v, n);
        @(posedge clk); #1;
        data_in = 1'b0;
    endtask

    task automatic idle();
        if (rand_ready) tri_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
    endtask

    task automatic send_tri(input int idx, input int base);
        send_vertex(idx, base, base / 2 + 5, ONE);
        send_vertex(idx, base + 30, base / 2 + 5, ONE + idx);
        send_vertex(idx, base + 10, base / 2 + 40, ONE);
    endtask

    task automatic clear_pulse();
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        exp_culled = 0;
        exp_seq = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic check_status(input string name, input bit exp_ovf);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (culled !== exp_culled[15:0]) begin
            errors++;
            $display("FAIL %s_culled got=%0d exp=%0d", name, culled, exp_culled);
        end
        checks++;
        if (seq_err !== exp_seq) begin
            errors++;
            $display("FAIL %s_seq_error got=%0b exp=%0b", name, seq_err, exp_seq);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_overflow got=%0b exp=%0b", name, ovf, exp_ovf);
        end
        $display("status %s culled=%0d seq=%0b ovf=%0b", name, culled, seq_err, ovf);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if ({tri_valid, tri_index, tri_u, bx0, bx1, by0, by1, af, seq_err, ovf, culled} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b valid=%b idx=%h exp=0", {bx0, bx1, by0, by1}, tri_valid, tri_index);
        end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tri_valid, tri_n, af, seq_err, ovf, culled} !== '0) begin
            errors++;
            $display("FAIL reset_release valid=%b af=%b culled=%0d exp=0", tri_valid, af, culled);
        end
        $display("reset checked");
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        tri_ready = 1'b1;
        send_vertex(5, 100, 50, ONE);
        send_vertex(5, 200, 60, ONE);
        send_vertex(5, 150, 120, ONE);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tri_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got=%b exp=0", tri_valid);
        end
        @(negedge clk);
        checks++;
        if (tri_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid got=%b exp=1", tri_valid);
        end
        checks++;
        if ({bx0, bx1, by0, by1} !== {10'd100, 10'd200, 10'd50, 10'd120}) begin
            errors++;
            $display("FAIL basic_bbox got=%0d..%0d,%0d..%0d exp=100..200,50..120", bx0, bx1, by0, by1);
        end
        wait_drain();
        check_status("basic", 1'b0);
    endtask

    task automatic test_cull();
        tri_ready = 1'b1;
        send_vertex(10, 100, 100, ONE);
        send_vertex(10, 200, 100, 0);
        send_vertex(10, 150, 200, ONE);
        send_vertex(11, 100, 100, ONE);
        send_vertex(11, 200, 100, -HALF);
        send_vertex(11, 150, 200, ONE);
        send_vertex(12, 640, 100, ONE);
        send_vertex(12, 900, 100, ONE);
        send_vertex(12, 700, 200, ONE);
        check_status("cull", 1'b0);
        checks++;
        if (culled !== 16'd3 || tri_valid !== 1'b0) begin
            errors++;
            $display("FAIL cull_count got=%0d valid=%b exp=3 valid=0", culled, tri_valid);
        end
    endtask

    task automatic test_clamp();
        logic [17:0] neg20;
        neg20 = -18'sd20;
        tri_ready = 1'b0;
        send_vertex(3, -20, 10, ONE);
        send_vertex(3, 700, 30, ONE);
        send_vertex(3, 300, 500, ONE);
        repeat (3) @(negedge clk);
        checks++;
        if ({bx0, bx1, by0, by1} !== {10'd0, 10'd639, 10'd10, 10'd479} || tri_u[0] !== neg20) begin
            errors++;
            $display("FAIL clamp_bbox got=%0d..%0d,%0d..%0d u0=%h exp=0..639,10..479 u0=%h",
                     bx0, bx1, by0, by1, tri_u[0], neg20);
        end
        tri_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_seq_error();
        tri_ready = 1'b1;
        send_vertex(7, 10, 10, ONE);
        send_vertex(7, 20, 10, ONE);
        send_vertex(8, 30, 30, ONE);
        send_vertex(8, 40, 30, ONE);
        send_vertex(8, 30, 60, ONE);
        wait_drain();
        check_status("seq", 1'b0);
        clear_pulse();
        @(negedge clk);
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL seq_clear got=%b exp=0", seq_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        tri_ready = 1'b0;
        send_tri(40, 10);
        repeat (3) @(negedge clk);
        checks++;
        if (af !== 1'b0) begin
            errors++;
            $display("FAIL af_occ1 got=%b exp=0", af);
        end
        @(posedge clk); #1;
        send_tri(41, 20);
        repeat (3) @(negedge clk);
        checks++;
        if (af !== 1'b1) begin
            errors++;
            $display("FAIL af_occ2 got=%b exp=1", af);
        end
        @(posedge clk); #1;
        send_tri(42, 30);
        send_tri(43, 40);
        send_tri(44, 50);
        void'(exp_q.pop_back());
        check_status("overflow", 1'b1);
        clear_pulse();
        // FIFO is full; the next push lands in the same cycle as a pop.
        send_tri(45, 60);
        @(posedge clk); #1;
        tri_ready = 1'b1;
        @(posedge clk); #1;
        tri_ready = 1'b0;
        check_status("full_pop", 1'b0);
        checks++;
        if (tri_valid !== 1'b1 || af !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_occ valid=%b af=%b exp=1 1", tri_valid, af);
        end
        tri_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_random();
        int base, t, bad, u, v, n;
        rand_ready = 1;
        for (int g = 0; g < 30; g++) begin
            t = 0;
            while (af && t < 100) begin
                idle();
                t++;
            end
            checks++;
            if (af) begin
                errors++;
                $display("FAIL random_af_stuck got=1 exp=0");
            end
            base = $urandom_range(0, 4095);
            for (int k = 0; k < 3; k++) begin
                bad = ($urandom_range(0, 11) == 0) ? 1 : 0;
                u = int'($urandom_range(0, 1000)) - 200;
                v = int'($urandom_range(0, 900)) - 200;
                n = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(0, 100)) : int'($urandom_range(1, 8000));
                send_vertex(bad ? (base ^ 1) : base, u, v, n);
                repeat ($urandom_range(0, 2)) idle();
            end
        end
        rand_ready = 0;
        tri_ready = 1'b1;
        wait_drain();
        check_status("random", 1'b0);
    endtask

    task automatic test_async_reset();
        tri_ready = 1'b0;
        send_tri(20, 100);
        repeat (3) @(negedge clk);
        checks++;
        if (tri_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup got=%b exp=1", tri_valid);
        end
        @(posedge clk); #1;
        send_vertex(21, 5, 5, ONE);
        send_vertex(21, 9, 5, ONE);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tri_valid, tri_index, tri_u, tri_v, bx0, bx1, by0, by1} !== '0) begin
            errors++;
            $display("FAIL areset_outputs valid=%b idx=%h exp=0", tri_valid, tri_index);
        end
        exp_q.delete();
        pend_q.delete();
        exp_culled = 0;
        exp_seq = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tri_ready = 1'b1;
        send_vertex(22, 300, 200, ONE);
        send_vertex(22, 320, 210, ONE);
        send_vertex(22, 310, 230, ONE);
        wait_drain();
        check_status("areset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cull();
        test_clamp();
        test_seq_error();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
